// File: rtl/hold_timer_array.sv
// N-channel hold-time detector: each channel flags once its input has been held high
// for T_eff consecutive cycles, with sticky or retrigger detection.

module hold_timer_ch #(
    parameter int CNT_W  = 20,
    parameter bit STICKY = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] t_eff,
    input  logic             data,
    input  logic             clr,
    output logic             det,
    output logic             pulse,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, CNTR, DONE} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pulse_n;
    logic [CNT_W:0]   cnt_inc;

    // One extra bit so the compare stays exact even when the threshold drops mid-count.
    assign cnt_inc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            pulse <= pulse_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (!en || clr) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: if (data) begin
                    cnt_n   = {{(CNT_W-1){1'b0}}, 1'b1};
                    state_n = (t_eff == {{(CNT_W-1){1'b0}}, 1'b1}) ? DONE : CNTR;
                end
                CNTR: if (!data) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt_inc >= {1'b0, t_eff}) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt_inc[CNT_W-1:0];
                end
                DONE: if (!STICKY && !data) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
        pulse_n = (state_n == DONE) && (state != DONE);
    end

    assign det  = (state == DONE);
    assign busy = (state == CNTR);
endmodule

module hold_timer_array #(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 20,
    parameter bit STICKY = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_thresh,
    input  logic [N_CH-1:0]  i_data,
    input  logic [N_CH-1:0]  i_clr,
    output logic [N_CH-1:0]  o_det,
    output logic [N_CH-1:0]  o_pulse,
    output logic [N_CH-1:0]  o_busy,
    output logic             o_any
);
    logic [CNT_W-1:0] t_eff;

    // A zero threshold behaves as one: detect on the first high sample.
    assign t_eff = (i_thresh == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : i_thresh;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        hold_timer_ch #(.CNT_W(CNT_W), .STICKY(STICKY)) u_ch (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .en     (i_en),
            .t_eff  (t_eff),
            .data   (i_data[g]),
            .clr    (i_clr[g]),
            .det    (o_det[g]),
            .pulse  (o_pulse[g]),
            .busy   (o_busy[g])
        );
    end

    assign o_any = |o_det;
endmodule

// File: tb/tb_hold_timer_array.sv
// Bench for hold_timer_array: a sticky and a retrigger instance share stimulus and are
// compared each cycle against a run-length reference model, plus directed sequences.

module tb_hold_timer_array;
    localparam int N  = 4;
    localparam int CW = 6;

    logic          i_clk, i_rst_n, i_en;
    logic [CW-1:0] i_thresh;
    logic [N-1:0]  i_data, i_clr;
    logic [N-1:0]  det_s, pulse_s, busy_s, det_r, pulse_r, busy_r;
    logic          any_s, any_r;

    int checks = 0;
    int failures = 0;

    hold_timer_array #(.N_CH(N), .CNT_W(CW), .STICKY(1'b1)) dut_s (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_thresh(i_thresh),
        .i_data(i_data), .i_clr(i_clr), .o_det(det_s), .o_pulse(pulse_s),
        .o_busy(busy_s), .o_any(any_s));

    hold_timer_array #(.N_CH(N), .CNT_W(CW), .STICKY(1'b0)) dut_r (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_thresh(i_thresh),
        .i_data(i_data), .i_clr(i_clr), .o_det(det_r), .o_pulse(pulse_r),
        .o_busy(busy_r), .o_any(any_r));

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Reference: length of the current qualifying high run and a detect flag per channel.
    int run_s[N], run_r[N];
    bit dm_s[N], dm_r[N], pm_s[N], pm_r[N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic ch_step(input bit sticky, input int k, inout int run, inout bit det,
                           output bit pls);
        int teff;
        teff = (i_thresh == 0) ? 1 : int'(i_thresh);
        pls = 1'b0;
        if (!i_en || i_clr[k]) begin
            run = 0; det = 1'b0;
        end else if (det) begin
            if (!sticky && !i_data[k]) begin
                run = 0; det = 1'b0;
            end
        end else if (i_data[k]) begin
            run++;
            if (run >= teff) begin
                det = 1'b1; pls = 1'b1;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            run_s[k] = 0; run_r[k] = 0;
            dm_s[k] = 0; dm_r[k] = 0; pm_s[k] = 0; pm_r[k] = 0;
        end
    endtask

    task automatic model_check();
        logic [N-1:0] ed_s, ep_s, eb_s, ed_r, ep_r, eb_r;
        for (int k = 0; k < N; k++) begin
            ed_s[k] = dm_s[k]; ep_s[k] = pm_s[k]; eb_s[k] = !dm_s[k] && run_s[k] > 0;
            ed_r[k] = dm_r[k]; ep_r[k] = pm_r[k]; eb_r[k] = !dm_r[k] && run_r[k] > 0;
        end
        check("s_det", 32'(det_s), 32'(ed_s));
        check("s_pulse", 32'(pulse_s), 32'(ep_s));
        check("s_busy", 32'(busy_s), 32'(eb_s));
        check("s_any", 32'(any_s), 32'(|ed_s));
        check("r_det", 32'(det_r), 32'(ed_r));
        check("r_pulse", 32'(pulse_r), 32'(ep_r));
        check("r_busy", 32'(busy_r), 32'(eb_r));
        check("r_any", 32'(any_r), 32'(|ed_r));
    endtask

    // Advance one edge with the inputs currently applied, then compare against the model.
    task automatic tick();
        for (int k = 0; k < N; k++) begin
            ch_step(1'b1, k, run_s[k], dm_s[k], pm_s[k]);
            ch_step(1'b0, k, run_r[k], dm_r[k], pm_r[k]);
        end
        @(posedge i_clk);
        #1;
        model_check();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        logic [N-1:0] data;
        logic [N-1:0] det;
        logic [N-1:0] pulse;
        logic [N-1:0] busy;
    } vec_t;
    vec_t tbl[10];

    initial begin
        // T=5: ch0 held 5 cycles; ch1 held 4, dropped 1, held 5 (sticky instance expectations)
        for (int i = 0; i < 4; i++) tbl[i] = '{4'b0011, 4'b0000, 4'b0000, 4'b0011};
        tbl[4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
        for (int i = 5; i < 9; i++) tbl[i] = '{4'b0010, 4'b0001, 4'b0000, 4'b0010};
        tbl[9] = '{4'b0010, 4'b0011, 4'b0010, 4'b0000};

        i_rst_n = 1'b0; i_en = 1'b0; i_thresh = '0; i_data = '0; i_clr = '0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        model_check();
        check("rst_det", 32'(det_s), 32'h0);
        #2 i_rst_n = 1'b1;

        i_en = 1'b1; i_thresh = 6'd5;
        for (int i = 0; i < 10; i++) begin
            i_data = tbl[i].data;
            tick();
            check("tbl_det", 32'(det_s), 32'(tbl[i].det));
            check("tbl_pulse", 32'(pulse_s), 32'(tbl[i].pulse));
            check("tbl_busy", 32'(busy_s), 32'(tbl[i].busy));
            check("tbl_any", 32'(any_s), 32'(|tbl[i].det));
        end

        // Sticky hold, clear, then a fresh full hold is required
        i_data = 4'b0100;
        ticks(5);
        check("stk_det", 32'(det_s[2]), 32'h1);
        check("stk_pulse", 32'(pulse_s[2]), 32'h1);
        i_data = 4'b0000;
        tick();
        check("stk_keep", 32'(det_s[2]), 32'h1);
        i_clr = 4'b0100;
        tick();
        i_clr = 4'b0000;
        check("stk_clr", 32'(det_s[2]), 32'h0);
        i_data = 4'b0100;
        ticks(4);
        check("stk_4hi", 32'(det_s[2]), 32'h0);
        tick();
        check("stk_5hi", 32'(det_s[2]), 32'h1);

        // Retrigger instance drops detection when input falls, without a pulse
        i_data = 4'b1000;
        ticks(5);
        check("rtg_det", 32'(det_r[3]), 32'h1);
        i_data = 4'b0000;
        tick();
        check("rtg_drop", 32'(det_r[3]), 32'h0);
        check("rtg_nopulse", 32'(pulse_r[3]), 32'h0);

        // Threshold 0 and 1 detect on the first high edge
        i_en = 1'b0; tick(); i_en = 1'b1;
        i_thresh = 6'd0; i_data = 4'b0001;
        tick();
        check("t0_det", 32'(det_s[0]), 32'h1);
        check("t0_pulse", 32'(pulse_s[0]), 32'h1);
        i_data = 4'b0000; i_en = 1'b0; tick(); i_en = 1'b1;
        i_thresh = 6'd1; i_data = 4'b0001;
        tick();
        check("t1_det", 32'(det_s[0]), 32'h1);

        // Threshold lowered below the running count
        i_en = 1'b0; tick(); i_en = 1'b1;
        i_thresh = 6'd8;
        ticks(6);
        check("lower_busy", 32'(busy_s[0]), 32'h1);
        i_thresh = 6'd3;
        tick();
        check("lower_det", 32'(det_s[0]), 32'h1);

        // Clear coincident with the detecting edge wins
        i_en = 1'b0; tick(); i_en = 1'b1;
        ticks(2);
        i_clr = 4'b0001;
        tick();
        check("clr_win_det", 32'(det_s[0]), 32'h0);
        check("clr_win_pulse", 32'(pulse_s[0]), 32'h0);
        i_clr = 4'b0000;

        // Largest threshold is reachable
        i_en = 1'b0; tick(); i_en = 1'b1;
        i_thresh = 6'd63;
        ticks(62);
        check("tmax_62", 32'(det_s[0]), 32'h0);
        tick();
        check("tmax_63", 32'(det_s[0]), 32'h1);
        check("tmax_pulse", 32'(pulse_s[0]), 32'h1);

        // Async reset mid-count clears everything between edges
        i_en = 1'b0; tick(); i_en = 1'b1;
        i_thresh = 6'd10; i_data = 4'b1111;
        ticks(3);
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_busy", 32'({busy_s, busy_r}), 32'h0);
        check("arst_out", 32'({det_s, pulse_s, det_r, pulse_r, 2'(any_s), 2'(any_r)}), 32'h0);
        model_reset();
        #2 i_rst_n = 1'b1;
        ticks(2);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            i_en = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 19) == 0) i_thresh = CW'($urandom_range(0, 6));
            for (int k = 0; k < N; k++) begin
                i_data[k] = ($urandom_range(0, 5) != 0);
                i_clr[k]  = ($urandom_range(0, 24) == 0);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
